// File: rtl/clock_display_driver.sv
// Snapshots binary sec/minute/hour on a load strobe and drives a multiplexed 6-digit 7-segment display.
// Define H12_MODE_EN for a 12-hour display with a registered pm output.
module clock_display_driver #(
  parameter int unsigned SCAN_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] minute_i,
  input  logic [4:0] hour_i,
  input  logic       load_i,
  output logic [5:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       err_o,
`ifdef H12_MODE_EN
  output logic       pm_o,
`endif
  output logic [2:0] dbg_idx_o
);

  localparam int unsigned      DIV_W   = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam bit               OUT_INV = (SEG_ACTIVE_LOW == 1'b0);

  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             pm_q, pm_d;

  logic             load_ok;
  logic [4:0]       hour_disp;
  logic [7:0]       sec_bcd, min_bcd, hour_bcd;
  logic [3:0]       digit;
  logic             blank;

  // Tens/units split by compare-and-subtract; valid for inputs up to 59.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    logic [3:0] u;
    if (v >= 6'd50)      begin t = 4'd5; u = 4'(v - 6'd50); end
    else if (v >= 6'd40) begin t = 4'd4; u = 4'(v - 6'd40); end
    else if (v >= 6'd30) begin t = 4'd3; u = 4'(v - 6'd30); end
    else if (v >= 6'd20) begin t = 4'd2; u = 4'(v - 6'd20); end
    else if (v >= 6'd10) begin t = 4'd1; u = 4'(v - 6'd10); end
    else                 begin t = 4'd0; u = v[3:0];         end
    return {t, u};
  endfunction

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
`ifdef H12_MODE_EN
    hour_disp = hour_q;
    if (hour_q == 5'd0)       hour_disp = 5'd12;
    else if (hour_q > 5'd12)  hour_disp = hour_q - 5'd12;
    pm_d = (hour_q >= 5'd12);
`else
    hour_disp = hour_q;
    pm_d      = 1'b0;
`endif
  end

  assign sec_bcd  = to_bcd(sec_q);
  assign min_bcd  = to_bcd(min_q);
  assign hour_bcd = to_bcd({1'b0, hour_disp});
  assign load_ok  = (sec_i <= 6'd59) && (minute_i <= 6'd59) && (hour_i <= 5'd23);

  always_comb begin
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    err_d  = err_q;
    div_d  = div_q + 1'b1;
    idx_d  = idx_q;
    if (load_i) begin
      if (load_ok) begin
        sec_d  = sec_i;
        min_d  = minute_i;
        hour_d = hour_i;
      end else begin
        err_d  = 1'b1;
      end
    end
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  always_comb begin
    digit = 4'd0;
    blank = 1'b0;
    case (idx_q)
      3'd0: digit = sec_bcd[3:0];
      3'd1: digit = sec_bcd[7:4];
      3'd2: digit = min_bcd[3:0];
      3'd3: digit = min_bcd[7:4];
      3'd4: digit = hour_bcd[3:0];
      3'd5: begin
        digit = hour_bcd[7:4];
        blank = (hour_bcd[7:4] == 4'd0);
      end
      default: digit = 4'd0;
    endcase
    an_d  = ~(6'b000001 << idx_q);
    seg_d = blank ? 7'b1111111 : seg7(digit);
    dp_d  = ~((idx_q == 3'd2) || (idx_q == 3'd4));
  end

  // Display registers are kept active-low internally; polarity is applied at the pins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      err_q  <= 1'b0;
      div_q  <= '0;
      idx_q  <= '0;
      an_q   <= 6'b111111;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
      pm_q   <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      err_q  <= err_d;
      div_q  <= div_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      pm_q   <= pm_d;
    end
  end

  assign an_o      = an_q ^ {6{OUT_INV}};
  assign seg_o     = seg_q ^ {7{OUT_INV}};
  assign dp_o      = dp_q ^ OUT_INV;
  assign err_o     = err_q;
  assign dbg_idx_o = idx_q;
`ifdef H12_MODE_EN
  assign pm_o      = pm_q;
`else
  logic unused_pm;
  assign unused_pm = pm_q;
`endif

endmodule

// File: tb/tb_clock_display_driver.sv
// Bench for clock_display_driver with SCAN_DIV=4, active-low outputs; honours H12_MODE_EN.
module tb_clock_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] sec = '0;
  logic [5:0] minute = '0;
  logic [4:0] hour = '0;
  logic       load = 1'b0;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       err;
  logic       pm;
  logic [2:0] dbg_idx;

  int n_cmp = 0;
  int n_err = 0;

  // Entry layout: {pm, err, dp, seg[6:0], an[5:0]}
  logic [15:0] exp_q[$];

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SB = 7'b1111111;

  clock_display_driver #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .sec_i    (sec),
    .minute_i (minute),
    .hour_i   (hour),
    .load_i   (load),
    .an_o     (an),
    .seg_o    (seg),
    .dp_o     (dp),
    .err_o    (err),
`ifdef H12_MODE_EN
    .pm_o     (pm),
`endif
    .dbg_idx_o(dbg_idx)
  );
`ifndef H12_MODE_EN
  assign pm = 1'b0;
`endif

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_scan(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                           input logic [6:0] s3, input logic [6:0] s4, input logic [6:0] s5,
                           input logic e, input logic p);
    exp_q.push_back({p, e, 1'b1, s0, 6'b111110});
    exp_q.push_back({p, e, 1'b1, s1, 6'b111101});
    exp_q.push_back({p, e, 1'b0, s2, 6'b111011});
    exp_q.push_back({p, e, 1'b1, s3, 6'b110111});
    exp_q.push_back({p, e, 1'b0, s4, 6'b101111});
    exp_q.push_back({p, e, 1'b1, s5, 6'b011111});
  endtask

  // Two reset edges, reset-state check, then release with an optional load on the first edge.
  // Returns at the negedge after the first active edge.
  task automatic start_test(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s,
                            input logic ld);
    rst  = 1'b1;
    load = 1'b0;
    step(2);
    check("reset_state", {2'b00, pm, err, dp, seg, an}, {3'b000, 1'b0, 1'b1, 7'b1111111, 6'b111111});
    rst    = 1'b0;
    hour   = h;
    minute = m;
    sec    = s;
    load   = ld;
    step(1);
    load = 1'b0;
  endtask

  // Scoreboard monitor: a new digit is presented whenever the enable pattern changes.
  logic [5:0] prev_an = 6'b111111;
  always @(negedge clk) begin
    if (an !== prev_an && exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      check("scan_digit", {pm, err, dp, seg, an}, e);
    end
    prev_an = an;
  end

  initial begin
    @(negedge clk);

    // Reset/scan timing with shadow 00:00:00
    start_test(5'd0, 6'd0, 6'd0, 1'b0);
    check("first_digit", {3'b0, dp, seg, an}, {3'b0, 1'b1, S0, 6'b111110});
    step(19);
    check("idx4_at_20", {10'b0, an}, {10'b0, 6'b101111});
    step(1);
`ifdef H12_MODE_EN
    check("idx5_at_21", {3'b0, dp, seg, an}, {3'b0, 1'b1, S1, 6'b011111});
    step(2);
    push_scan(S0, S0, S0, S0, S2, S1, 1'b0, 1'b0);
`else
    check("idx5_at_21", {3'b0, dp, seg, an}, {3'b0, 1'b1, SB, 6'b011111});
    step(2);
    push_scan(S0, S0, S0, S0, S0, SB, 1'b0, 1'b0);
`endif
    step(1);
    check("idx5_held_24", {10'b0, an}, {10'b0, 6'b011111});
    step(1);
    check("wrap_at_25", {10'b0, an}, {10'b0, 6'b111110});
    step(22);

    // 23:59:58
    start_test(5'd23, 6'd59, 6'd58, 1'b1);
    step(22);
`ifdef H12_MODE_EN
    push_scan(S8, S5, S9, S5, S1, S1, 1'b0, 1'b1);
`else
    push_scan(S8, S5, S9, S5, S3, S2, 1'b0, 1'b0);
`endif
    step(24);

    // Out-of-range capture is dropped and err sticks through a later valid load
    start_test(5'd10, 6'd20, 6'd30, 1'b1);
    hour = 5'd11; minute = 6'd11; sec = 6'd60; load = 1'b1;
    step(1);
    hour = 5'd10; minute = 6'd20; sec = 6'd30; load = 1'b1;
    step(1);
    load = 1'b0;
    check("err_set", {15'b0, err}, 16'd1);
    step(20);
    push_scan(S0, S3, S0, S2, S0, S1, 1'b1, 1'b0);
    step(24);

    // Leading-zero blank on hour tens, 05:07:41
    start_test(5'd5, 6'd7, 6'd41, 1'b1);
    step(22);
    push_scan(S1, S4, S7, S0, S5, SB, 1'b0, 1'b0);
    step(24);

`ifdef H12_MODE_EN
    start_test(5'd0, 6'd0, 6'd0, 1'b1);
    step(22);
    push_scan(S0, S0, S0, S0, S2, S1, 1'b0, 1'b0);
    step(24);
    start_test(5'd13, 6'd0, 6'd0, 1'b1);
    step(22);
    push_scan(S0, S0, S0, S0, S1, SB, 1'b0, 1'b1);
    step(24);
    start_test(5'd12, 6'd0, 6'd0, 1'b1);
    step(22);
    push_scan(S0, S0, S0, S0, S2, S1, 1'b0, 1'b1);
    step(24);
`endif

    // Reset mid-scan at idx 3 with load high wins over the load
    start_test(5'd24, 6'd0, 6'd0, 1'b1);
    check("err_hour24", {15'b0, err}, 16'd1);
    step(12);
    rst = 1'b1; load = 1'b1; hour = 5'd12; minute = 6'd34; sec = 6'd56;
    step(1);
    check("midscan_reset", {2'b00, pm, err, dp, seg, an}, {3'b000, 1'b0, 1'b1, 7'b1111111, 6'b111111});
    step(1);
    rst = 1'b0; load = 1'b0;
    step(1);
    step(22);
`ifdef H12_MODE_EN
    push_scan(S0, S0, S0, S0, S2, S1, 1'b0, 1'b0);
`else
    push_scan(S0, S0, S0, S0, S0, SB, 1'b0, 1'b0);
`endif
    step(24);

    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(1);
    check("queue_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
